// File: rtl/pixel_writer.sv
// pixel_writer: host write port into the double-buffered 64x48x4bpp framebuffer.
// Accepts write / fill / swap commands, turns (x,y) into bank/addr/pixSel
// nibble addressing and issues single-nibble writes through the arbiter.
// Optional feature macro: PIXEL_WRITER_FILL_EN builds the FILL state and counter.
module pixel_writer #(
  parameter int H_PIX = 64,
  parameter int V_PIX = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [5:0] cmd_x,
  input  logic [5:0] cmd_y,
  input  logic [3:0] cmd_color,
  input  logic       frame_end,
  input  logic       mem_gnt,
  output logic       mem_we,
  output logic       bank,
  output logic [8:0] addr,
  output logic [2:0] pixSel,
  output logic [3:0] pixelOut,
  output logic       disp_bank,
  output logic       busy
);

  localparam int XW = (H_PIX > 1) ? $clog2(H_PIX) : 0;
`ifdef PIXEL_WRITER_FILL_EN
  localparam logic [11:0] LAST_IDX = 12'(H_PIX * V_PIX - 1);
`endif

`ifdef PIXEL_WRITER_FILL_EN
  typedef enum logic [1:0] {IDLE, WRITE, FILL, SWAP_WAIT} state_e;
`else
  typedef enum logic [1:0] {IDLE, WRITE, SWAP_WAIT} state_e;
`endif

  state_e      state_q, state_d;
  // idx_q holds the write address; during FILL it doubles as the fill counter
  logic [11:0] idx_q, idx_d;
  logic [3:0]  color_q, color_d;
  logic        disp_q, disp_d;
  logic        we_q, ready_q, busy_q;
  logic        we_d;

  logic [11:0] idx_in;
  logic        in_range;

  // H_PIX is a power of two, so the row multiply is a shift
  assign idx_in   = (12'(cmd_y) << XW) + 12'(cmd_x);
  assign in_range = (32'(cmd_x) < H_PIX) && (32'(cmd_y) < V_PIX);

  // next-state: command decode in IDLE, grant/frame_end handling elsewhere
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    color_d = color_q;
    disp_d  = disp_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            2'b00: begin
              // out-of-range writes are swallowed without touching memory
              if (in_range) begin
                state_d = WRITE;
                idx_d   = idx_in;
                color_d = cmd_color;
              end
            end
`ifdef PIXEL_WRITER_FILL_EN
            2'b01: begin
              state_d = FILL;
              idx_d   = '0;
              color_d = cmd_color;
            end
`endif
            2'b10:   state_d = SWAP_WAIT;
            default: ;
          endcase
        end
      end
      WRITE: begin
        if (mem_gnt) state_d = IDLE;
      end
`ifdef PIXEL_WRITER_FILL_EN
      FILL: begin
        // counter only moves on granted cycles, so gaps never drop an index
        if (mem_gnt) begin
          if (idx_q == LAST_IDX) state_d = IDLE;
          else                   idx_d   = idx_q + 12'd1;
        end
      end
`endif
      SWAP_WAIT: begin
        // frame_end on the acceptance edge was sampled while still IDLE
        if (frame_end) begin
          disp_d  = ~disp_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // write-request decode of the next state, so mem_we comes straight off a flop
  always_comb begin
    we_d = (state_d == WRITE);
`ifdef PIXEL_WRITER_FILL_EN
    if (state_d == FILL) we_d = 1'b1;
`endif
  end

  // state and registered outputs; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      color_q <= '0;
      disp_q  <= 1'b0;
      we_q    <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      color_q <= color_d;
      disp_q  <= disp_d;
      we_q    <= we_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign mem_we    = we_q;
  assign addr      = idx_q[11:3];
  assign pixSel    = idx_q[2:0];
  assign pixelOut  = color_q;
  assign disp_bank = disp_q;
  // writes always land in the buffer that is not being scanned out
  assign bank      = ~disp_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer with a write scoreboard.
module tb_pixel_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [5:0] cmd_x, cmd_y;
  logic [3:0] cmd_color;
  logic       frame_end;
  logic       mem_gnt;
  logic       mem_we;
  logic       bank;
  logic [8:0] addr;
  logic [2:0] pixSel;
  logic [3:0] pixelOut;
  logic       disp_bank;
  logic       busy;

  typedef struct packed {
    logic       bnk;
    logic [8:0] adr;
    logic [2:0] sel;
    logic [3:0] pix;
  } wr_t;

  wr_t sb[$];
  int  checks   = 0;
  int  failures = 0;
  int  wr_cnt   = 0;

  pixel_writer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color),
    .frame_end(frame_end), .mem_gnt(mem_gnt), .mem_we(mem_we), .bank(bank),
    .addr(addr), .pixSel(pixSel), .pixelOut(pixelOut), .disp_bank(disp_bank),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic wr_t mk(input logic b, input int idx, input logic [3:0] c);
    wr_t w;
    w.bnk = b;
    w.adr = 9'(idx >> 3);
    w.sel = 3'(idx & 7);
    w.pix = c;
    return w;
  endfunction

  // every granted write is compared with the oldest expected write
  always @(negedge clk) begin
    if (!rst && mem_we === 1'b1 && mem_gnt === 1'b1) begin
      wr_t got, exp;
      wr_cnt++;
      got = {bank, addr, pixSel, pixelOut};
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write observed=%0h expected=none", got);
      end
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        checks++;
        assert (got === exp) else begin
          failures++;
          $error("FAIL write_data observed=%0h expected=%0h", got, exp);
        end
      end
    end
  end

  // issue one command; called #1 after a rising edge, returns #1 after the handshake edge
  task automatic send(input logic [1:0] op, input logic [5:0] x, input logic [5:0] y,
                      input logic [3:0] c, input logic fe);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_color = c; frame_end = fe;
    @(posedge clk); #1;
    cmd_valid = 1'b0; frame_end = 1'b0;
  endtask

  initial begin
    int n, base;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0;
    cmd_color = '0; frame_end = 1'b0; mem_gnt = 1'b0;
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_bank", {disp_bank, bank}, 2'b01);
    chk("rst_addr", {addr, pixSel, pixelOut}, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // basic write, grant tied high
    mem_gnt = 1'b1;
    sb.push_back(mk(1'b1, 3*64+5, 4'hA));
    send(2'b00, 6'd5, 6'd3, 4'hA, 1'b0);
    chk("w1_we", mem_we, 1);
    chk("w1_ready_low", cmd_ready, 0);
    chk("w1_addr", {addr, pixSel}, {9'h018, 3'd5});
    @(posedge clk); #1;
    chk("w1_ready_back", cmd_ready, 1);
    chk("w1_we_off", mem_we, 0);
    chk("w1_cnt", wr_cnt, 1);

    // corner write with grant held low for four cycles
    mem_gnt = 1'b0;
    sb.push_back(mk(1'b1, 47*64+63, 4'h7));
    send(2'b00, 6'd63, 6'd47, 4'h7, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("w2_hold", {mem_we, addr, pixSel, pixelOut}, {1'b1, 9'h17F, 3'd7, 4'h7});
    end
    @(posedge clk); #1; mem_gnt = 1'b1;
    @(negedge clk);
    chk("w2_we5", mem_we, 1);
    @(posedge clk); #1;
    chk("w2_we_off", mem_we, 0);
    @(posedge clk); #1;
    chk("w2_one_grant", wr_cnt, 2);

    // out-of-range row is swallowed
    send(2'b00, 6'd0, 6'd48, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("oor_idle", {mem_we, cmd_ready, busy}, 3'b010);
    end
    @(posedge clk); #1;

    // fill with grant toggling every cycle
    base = wr_cnt;
`ifdef PIXEL_WRITER_FILL_EN
    for (int i = 0; i < 3072; i++) sb.push_back(mk(1'b1, i, 4'h3));
`endif
    mem_gnt = 1'b0;
    send(2'b01, 6'd0, 6'd0, 4'h3, 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 8000) begin
      mem_gnt = ~mem_gnt;
      @(posedge clk); #1; n++;
    end
    chk("fill_timeout", (n < 8000), 1);
    mem_gnt = 1'b0;
`ifdef PIXEL_WRITER_FILL_EN
    chk("fill_count", wr_cnt - base, 3072);
`else
    chk("fill_count", wr_cnt - base, 0);
`endif
    chk("fill_sb_empty", sb.size(), 0);
    chk("fill_idle", {cmd_ready, mem_we}, 2'b10);

    // swap: pulse on acceptance edge ignored, second pulse swaps
    send(2'b10, 6'd0, 6'd0, 4'h0, 1'b1);
    chk("swap_busy", busy, 1);
    chk("swap_no_early", {disp_bank, bank}, 2'b01);
    repeat (9) begin @(posedge clk); #1; end
    chk("swap_wait", {busy, disp_bank}, 2'b10);
    frame_end = 1'b1;
    @(posedge clk); #1; frame_end = 1'b0;
    chk("swap_done", {disp_bank, bank, busy, cmd_ready}, 4'b1001);

    // write now targets bank 0
    mem_gnt = 1'b1;
    sb.push_back(mk(1'b0, 1, 4'h2));
    send(2'b00, 6'd1, 6'd0, 4'h2, 1'b0);
    @(posedge clk); #1;
    chk("bank0_write", sb.size(), 0);

`ifdef PIXEL_WRITER_FILL_EN
    // reset in the middle of a fill at index 100
    for (int i = 0; i < 100; i++) sb.push_back(mk(1'b0, i, 4'h5));
    send(2'b01, 6'd0, 6'd0, 4'h5, 1'b0);
    n = 0;
    while (!(mem_we === 1'b1 && {addr, pixSel} === 12'd100) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    chk("fill100_reached", (n < 500), 1);
    rst = 1'b1; #1;
`else
    // reset while a swap is pending
    send(2'b10, 6'd0, 6'd0, 4'h0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; #1;
`endif
    chk("mid_rst_ctl", {cmd_ready, busy, mem_we}, 3'b100);
    chk("mid_rst_bank", {disp_bank, bank}, 2'b01);
    chk("mid_rst_addr", {addr, pixSel, pixelOut}, 0);
    chk("mid_rst_sb", sb.size(), 0);
    @(posedge clk); #1; rst = 1'b0;
    frame_end = 1'b1;
    @(posedge clk); #1; frame_end = 1'b0;
    chk("no_stale_swap", disp_bank, 0);

    // first command after reset is taken at once
    mem_gnt = 1'b1;
    sb.push_back(mk(1'b1, 66, 4'h9));
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_x = 6'd2; cmd_y = 6'd1; cmd_color = 4'h9;
    @(posedge clk); #1; cmd_valid = 1'b0;
    chk("post_rst_we", mem_we, 1);
    @(posedge clk); #1;
    chk("post_rst_sb", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
